// File: rtl/mux_sel_arbiter_if.sv
// mux_sel_arbiter_if
//   Bundles the requester-facing bus of the mux_sel_arbiter.
//   master : requester side, drives req and the four data words, sees the results.
//   slave  : arbiter side, samples req/data and drives the grant and the output word.
// Signals
//   req       [3:0] level request per requester
//   data1..4  [4:0] word offered by requester 0..3
//   grant     [3:0] one-hot grant, 0 when idle
//   sel       [1:0] index of the current owner (mux select)
//   data_out  [4:0] registered mux output
//   out_valid       data_out holds a granted beat
//   expire          one-cycle pulse on a forced handover
interface mux_sel_arbiter_if;
  logic [3:0] req;
  logic [4:0] data1;
  logic [4:0] data2;
  logic [4:0] data3;
  logic [4:0] data4;
  logic [3:0] grant;
  logic [1:0] sel;
  logic [4:0] data_out;
  logic       out_valid;
  logic       expire;

  modport master (
    output req, data1, data2, data3, data4,
    input  grant, sel, data_out, out_valid, expire
  );

  modport slave (
    input  req, data1, data2, data3, data4,
    output grant, sel, data_out, out_valid, expire
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter
//   Round-robin arbiter that shares one Mux5bit4to1 between four requesters.
//   The owner is granted one-hot, the mux select follows the owner, and the
//   selected word is registered together with a valid flag.
// Ports
//   clk  in  single clock, rising edge
//   rst  in  asynchronous active-low reset
//   bus  mux_sel_arbiter_if.slave (req, data1..4 in; grant, sel, data_out,
//        out_valid, expire out)
// Parameters
//   MAX_HOLD   beats an owner may keep the grant while others wait (1..255),
//              only meaningful with the timeout feature
//   RESET_PTR  last-winner pointer after reset (0..3); 3 puts req[0] first
// Build option
//   ARB_TIMEOUT_EN  when defined, an owner that holds MAX_HOLD beats while
//                   others are waiting is forced to hand over and expire
//                   pulses; when undefined the owner holds until it drops req
//                   and expire is tied low.

module Mux5bit4to1 (
  input  logic [4:0] data1,
  input  logic [4:0] data2,
  input  logic [4:0] data3,
  input  logic [4:0] data4,
  input  logic [1:0] sel,
  output logic [4:0] out
);
  always_comb begin
    out = data1;
    case (sel)
      2'd0: out = data1;
      2'd1: out = data2;
      2'd2: out = data3;
      2'd3: out = data4;
    endcase
  end
endmodule

module mux_sel_arbiter #(
  parameter int MAX_HOLD  = 8,
  parameter int RESET_PTR = 3
) (
  input  logic               clk,
  input  logic               rst,
  mux_sel_arbiter_if.slave   bus
);

  // Elaboration-time range guards on the configuration.
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux_sel_arbiter: MAX_HOLD must be within 1..255");
  end
  if (RESET_PTR < 0 || RESET_PTR > 3) begin : g_bad_reset_ptr
    $error("mux_sel_arbiter: RESET_PTR must be within 0..3");
  end

  localparam logic [1:0] RST_PTR = 2'(RESET_PTR);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_reg;
  logic [3:0] grant_reg;
  logic [1:0] sel_reg;
  logic [4:0] data_out_reg;
  logic       out_valid_reg;
  logic [1:0] ptr_reg;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt_reg;
  logic       expire_reg;
`endif

  logic [4:0] mux_out;
  logic       beat;
  logic [3:0] others;
  logic [3:0] arb_cand;
  logic [1:0] arb_base;
  logic [1:0] next_owner;
  logic [3:0] next_onehot;

  Mux5bit4to1 u_mux (
    .data1 (bus.data1),
    .data2 (bus.data2),
    .data3 (bus.data3),
    .data4 (bus.data4),
    .sel   (sel_reg),
    .out   (mux_out)
  );

  // First set bit of cand, searching base+1, base+2, ... modulo 4.
  function automatic logic [1:0] arb_pick(input logic [3:0] cand, input logic [1:0] base);
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    pick  = base;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = base + 2'(i);
      if (!found && cand[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign beat   = bus.req[sel_reg] & grant_reg[sel_reg];
  // grant is one-hot on sel, so this is req with the owner masked out.
  assign others = bus.req & ~grant_reg;

  // From IDLE the search starts after the stored last winner; during a
  // handover the outgoing owner becomes the last winner in the same edge, so
  // the search starts directly after sel.
  assign arb_cand   = (state_reg == IDLE) ? bus.req : others;
  assign arb_base   = (state_reg == IDLE) ? ptr_reg : sel_reg;
  assign next_owner = arb_pick(arb_cand, arb_base);

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_onehot
    assign next_onehot[gi] = (next_owner == 2'(gi));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      grant_reg     <= 4'b0000;
      sel_reg       <= 2'd0;
      data_out_reg  <= 5'd0;
      out_valid_reg <= 1'b0;
      ptr_reg       <= RST_PTR;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_reg  <= 8'd0;
      expire_reg    <= 1'b0;
`endif
    end else begin
      out_valid_reg <= beat;
      if (beat) begin
        data_out_reg <= mux_out;
      end
`ifdef ARB_TIMEOUT_EN
      expire_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
`ifdef ARB_TIMEOUT_EN
          hold_cnt_reg <= 8'd0;
`endif
          if (|bus.req) begin
            state_reg <= GRANT;
            grant_reg <= next_onehot;
            sel_reg   <= next_owner;
          end
        end
        GRANT: begin
          if (bus.req[sel_reg]) begin
`ifdef ARB_TIMEOUT_EN
            if (hold_cnt_reg == HOLD_LAST && (|others)) begin
              // Forced handover; the old owner keeps req high and re-queues.
              ptr_reg      <= sel_reg;
              grant_reg    <= next_onehot;
              sel_reg      <= next_owner;
              hold_cnt_reg <= 8'd0;
              expire_reg   <= 1'b1;
            end else if (hold_cnt_reg != 8'hFF) begin
              hold_cnt_reg <= hold_cnt_reg + 8'd1;
            end
`endif
          end else begin
            ptr_reg <= sel_reg;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_reg <= 8'd0;
`endif
            if (|others) begin
              // Back-to-back handover, no idle cycle in between.
              grant_reg <= next_onehot;
              sel_reg   <= next_owner;
            end else begin
              state_reg <= IDLE;
              grant_reg <= 4'b0000;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_reg;
  assign bus.sel       = sel_reg;
  assign bus.data_out  = data_out_reg;
  assign bus.out_valid = out_valid_reg;
`ifdef ARB_TIMEOUT_EN
  assign bus.expire    = expire_reg;
`else
  assign bus.expire    = 1'b0;
`endif

endmodule
